// File: rtl/sk6812_chain_driver_if.sv
// Host-side bus for the SK6812 chain driver: pixel writes plus frame control.
// master = host (wr_en/wr_addr/wr_data/start), slave = driver (wr_err/busy/done).
interface sk6812_chain_driver_if #(
    parameter int NUM_LEDS     = 2,
    parameter int BITS_PER_LED = 24
);
    localparam int AW = $clog2(NUM_LEDS);

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [BITS_PER_LED-1:0] wr_data;
    logic                    wr_err;
    logic                    start;
    logic                    busy;
    logic                    done;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  wr_err, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output wr_err, busy, done
    );
endinterface

// File: rtl/sk6812_chain_driver.sv
// SK6812 one-wire chain driver: serialises NUM_LEDS pixel words from a small RAM.
// Ports: clk, rst_n (sync, active low), bus (slave: writes, start/busy/done), ledstr.
module sk6812_chain_driver #(
    parameter int NUM_LEDS     = 2,
    parameter int BITS_PER_LED = 24,
    parameter int BIT_CYC      = 15,
    parameter int T0H_CYC      = 4,
    parameter int T1H_CYC      = 7,
    parameter int RESET_CYC    = 1000,
    parameter bit INVERT_OUT   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sk6812_chain_driver_if.slave bus,
    output logic                 ledstr
);
    localparam int AW  = $clog2(NUM_LEDS);
    localparam int BW  = BITS_PER_LED;
    localparam int BCW = $clog2(BITS_PER_LED);
    localparam int CW  = $clog2(BIT_CYC + 1);
    localparam int RW  = $clog2(RESET_CYC + 1);

    localparam logic [AW:0]    N_EXT    = (AW+1)'(NUM_LEDS);
    localparam logic [AW-1:0]  LAST_PIX = AW'(NUM_LEDS - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS_PER_LED - 1);
    localparam logic [CW-1:0]  LAST_CYC = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0]  T0H_W    = CW'(T0H_CYC);
    localparam logic [CW-1:0]  T1H_W    = CW'(T1H_CYC);
    localparam logic [RW-1:0]  LAST_LAT = RW'(RESET_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_t;

    state_t         state;
    logic [BW-1:0]  ram [NUM_LEDS];
    logic [BW-1:0]  rd_data;
    logic [BW-1:0]  shreg;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  pix_cnt;
    logic [BCW-1:0] bit_cnt;
    logic [CW-1:0]  cyc_cnt;
    logic [CW-1:0]  cyc_nxt;
    logic [CW-1:0]  high_len;
    logic [RW-1:0]  lat_cnt;
    logic           line;
    logic           busy_q;
    logic           done_q;
    logic           werr_q;
    logic           wr_ok;
    logic           cur_bit;

    assign wr_ok = bus.wr_en && !busy_q && ({1'b0, bus.wr_addr} < N_EXT);

    // Prefetch the next pixel while the current one shifts out; pixel 0
    // is read during LOAD so a write accepted with start is picked up.
    assign rd_addr = (state == S_BIT && pix_cnt != LAST_PIX) ?
                     pix_cnt + AW'(1) : '0;

    // The bit value is first needed when leaving cycle 0 of a bit (cycle 0
    // is high for either value), so the word is latched on that edge.
    always_comb begin
        cur_bit = shreg[BW-1];
        if (cyc_cnt == '0)
            cur_bit = (bit_cnt == '0) ? rd_data[BW-1] : shreg[BW-2];
        high_len = cur_bit ? T1H_W : T0H_W;
        cyc_nxt  = cyc_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            ram[bus.wr_addr] <= bus.wr_data;
        rd_data <= ram[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pix_cnt <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            lat_cnt <= '0;
            shreg   <= '0;
            line    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            werr_q <= bus.wr_en && !wr_ok;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state   <= S_BIT;
                    pix_cnt <= '0;
                    bit_cnt <= '0;
                    cyc_cnt <= '0;
                    line    <= 1'b1;
                end
                S_BIT: begin
                    if (cyc_cnt == LAST_CYC) begin
                        cyc_cnt <= '0;
                        line    <= 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (pix_cnt == LAST_PIX) begin
                                state   <= S_LATCH;
                                lat_cnt <= '0;
                                line    <= 1'b0;
                            end else begin
                                pix_cnt <= pix_cnt + AW'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_nxt;
                        line    <= (cyc_nxt < high_len);
                        if (cyc_cnt == '0)
                            shreg <= (bit_cnt == '0) ? rd_data : (shreg << 1);
                    end
                end
                S_LATCH: begin
                    if (lat_cnt == LAST_LAT) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + RW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wr_err = werr_q;
    assign ledstr     = INVERT_OUT ? ~line : line;
endmodule

// File: tb/tb_sk6812_chain_driver.sv
// Bench for sk6812_chain_driver: three instances (2x24 inv, 5x32 inv, 2x24 non-inv)
// checked every cycle against a frame-offset model, plus literal timing checks.
`timescale 1ns/1ps
module tb_sk6812_chain_driver;
    localparam int C  = 15;
    localparam int T0 = 4;
    localparam int T1 = 7;
    localparam int R  = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en   [3];
    logic [2:0]  addr [3];
    logic [31:0] data [3];
    logic        st   [3];
    logic        led_a, led_b, led_c;
    logic [3:0]  obs  [3];

    sk6812_chain_driver_if #(.NUM_LEDS(2), .BITS_PER_LED(24)) ia ();
    sk6812_chain_driver_if #(.NUM_LEDS(5), .BITS_PER_LED(32)) ib ();
    sk6812_chain_driver_if #(.NUM_LEDS(2), .BITS_PER_LED(24)) ic ();

    sk6812_chain_driver #(.NUM_LEDS(2), .BITS_PER_LED(24), .INVERT_OUT(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave), .ledstr(led_a));
    sk6812_chain_driver #(.NUM_LEDS(5), .BITS_PER_LED(32), .INVERT_OUT(1'b1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave), .ledstr(led_b));
    sk6812_chain_driver #(.NUM_LEDS(2), .BITS_PER_LED(24), .INVERT_OUT(1'b0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave), .ledstr(led_c));

    assign ia.wr_en = en[0];  assign ia.wr_addr = addr[0][0];
    assign ia.wr_data = data[0][23:0];  assign ia.start = st[0];
    assign ib.wr_en = en[1];  assign ib.wr_addr = addr[1];
    assign ib.wr_data = data[1];  assign ib.start = st[1];
    assign ic.wr_en = en[2];  assign ic.wr_addr = addr[2][0];
    assign ic.wr_data = data[2][23:0];  assign ic.start = st[2];

    assign obs[0] = {led_a, ia.busy, ia.done, ia.wr_err};
    assign obs[1] = {led_b, ib.busy, ib.done, ib.wr_err};
    assign obs[2] = {led_c, ic.busy, ic.done, ic.wr_err};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    // Model: pixel RAM image, plus the edge at which the current frame was accepted.
    int          pn   [3] = '{2, 5, 2};
    int          pbits[3] = '{24, 32, 24};
    bit          pinv [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] mram [3][5];
    bit          act  [3];
    int          mk   [3];
    bit          mwerr[3];

    task automatic chk(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    function automatic int frame_len(int i);
        return pn[i] * pbits[i] * C;
    endfunction

    always @(posedge clk) begin
        bit bz;
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            bz = act[i] && ((cyc - 1 - mk[i]) <= frame_len(i) + R);
            if (!rst_n) begin
                act[i]   = 1'b0;
                mwerr[i] = 1'b0;
            end else begin
                mwerr[i] = en[i] && (bz || addr[i] >= pn[i]);
                if (en[i] && !bz && addr[i] < pn[i])
                    mram[i][addr[i]] = data[i];
                if (st[i] && !bz) begin
                    act[i] = 1'b1;
                    mk[i]  = cyc;
                end
            end
        end
    end

    // Expected {ledstr, busy, done, wr_err} from the offset into the frame.
    function automatic logic [3:0] expect_o(int i);
        int d, f, j, c, p;
        logic ln, bz, dn, v;
        f = frame_len(i);
        ln = 1'b0; bz = 1'b0; dn = 1'b0;
        if (act[i]) begin
            d = cyc - mk[i];
            bz = (d >= 0 && d <= f + R);
            if (d >= 1 && d <= f) begin
                j  = (d - 1) / C;
                c  = (d - 1) % C;
                p  = j / pbits[i];
                v  = mram[i][p][pbits[i] - 1 - (j % pbits[i])];
                ln = (c < (v ? T1 : T0));
            end
            dn = (d == f + R + 1);
        end
        return {ln ^ pinv[i], bz, dn, mwerr[i]};
    endfunction

    always @(negedge clk) begin
        logic [3:0] e;
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                e = expect_o(i);
                n_cmp++;
                if (obs[i] !== e) begin
                    n_err++;
                    $display("FAIL cycle dut%0d @%0d {led,busy,done,wr_err}: got %b want %b",
                             i, cyc, obs[i], e);
                end
            end
        end
    end

    // Pulse measurement on the uninverted lines of A and B.
    int   hw_a[$], rise_a[$], done_a[$], hw_b[$];
    int   run_a = 0, run_b = 0, dn_c = 0;
    logic prev_a = 1'b0;
    always @(negedge clk) begin
        logic la, lb;
        if (chk_on) begin
            la = ~led_a;
            lb = ~led_b;
            if (la) run_a++;
            else if (run_a > 0) begin hw_a.push_back(run_a); run_a = 0; end
            if (lb) run_b++;
            else if (run_b > 0) begin hw_b.push_back(run_b); run_b = 0; end
            if (la && !prev_a) rise_a.push_back(cyc + 1);
            prev_a = la;
            if (ia.done) done_a.push_back(cyc + 1);
            if (ic.done) dn_c++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(int i, int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (obs[i][1] !== 1'b1 && n < budget);
        chk($sformatf("done_seen_dut%0d", i), int'(obs[i][1] === 1'b1), 1);
    endtask

    logic [31:0] img_b[5];
    logic [31:0] nw;
    int k, bad, sz;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; addr[i] = '0; data[i] = '0; st[i] = 1'b0;
        end
        repeat (3) tick();
        @(negedge clk);
        chk("rst_led_a", int'(led_a), 1);
        chk("rst_busy_a", int'(ia.busy), 0);
        chk("rst_done_a", int'(ia.done), 0);
        chk("rst_led_c", int'(led_c), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        tick();

        // Single frames: A/C fixed pattern, B random RGBW with pix4 = 1.
        for (int p = 0; p < 5; p++) begin
            img_b[p] = (p == 4) ? 32'h0000_0001 : $urandom;
            en[1] = 1'b1; addr[1] = 3'(p); data[1] = img_b[p];
            en[0] = (p < 2); en[2] = (p < 2);
            addr[0] = 3'(p % 2); addr[2] = 3'(p % 2);
            data[0] = (p == 0) ? 32'hF0_0000 : 32'h00_000F;
            data[2] = data[0];
            tick();
        end
        en[0] = 1'b0; en[1] = 1'b0; en[2] = 1'b0;
        st[0] = 1'b1; st[1] = 1'b1; st[2] = 1'b1;
        k = cyc + 1;
        tick();
        st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
        @(negedge clk);
        chk("load_led_c", int'(led_c), 0);
        @(negedge clk);
        chk("first_high_c", int'(led_c), 1);
        chk("first_high_a", int'(led_a), 0);

        en[1] = 1'b1; addr[1] = 3'd4; data[1] = 32'h0;
        tick();
        en[1] = 1'b0;
        @(negedge clk);
        chk("wr_err_busy", int'(ib.wr_err), 1);

        wait_done(0, 2000);
        tick();
        chk("first_rise_a", rise_a.size() > 0 ? rise_a[0] : -1, k + 2);
        chk("high_count_a", hw_a.size(), 48);
        bad = 0;
        foreach (hw_a[m]) if (hw_a[m] != ((m < 4 || m >= 44) ? 7 : 4)) bad++;
        chk("high_widths_a", bad, 0);
        bad = 0;
        for (int m = 1; m < rise_a.size(); m++) if (rise_a[m] - rise_a[m-1] != 15) bad++;
        chk("bit_period_a", bad, 0);
        chk("done_edge_a", done_a.size() > 0 ? done_a[0] : -1, k + 1722);

        wait_done(1, 4000);
        tick();
        chk("high_count_b", hw_b.size(), 160);
        chk("last_bit_b", hw_b.size() > 0 ? hw_b[hw_b.size() - 1] : -1, 7);
        bad = 0;
        foreach (hw_b[j])
            if (j < 160 && int'(hw_b[j] == 7) != int'(img_b[j / 32][31 - j % 32])) bad++;
        chk("stream_b", bad, 0);

        en[1] = 1'b1; addr[1] = 3'd5; data[1] = $urandom;
        tick();
        en[1] = 1'b0;
        @(negedge clk);
        chk("wr_err_addr", int'(ib.wr_err), 1);
        @(negedge clk);
        chk("wr_err_pulse", int'(ib.wr_err), 0);

        // Write and start in the same cycle.
        nw = $urandom;
        hw_a.delete();
        en[0] = 1'b1; addr[0] = 3'd1; data[0] = nw; st[0] = 1'b1;
        tick();
        en[0] = 1'b0; st[0] = 1'b0;
        wait_done(0, 2000);
        tick();
        chk("new_word_last_bit", hw_a.size() > 0 ? hw_a[hw_a.size() - 1] : -1,
            nw[0] ? 7 : 4);

        // Start held on A with random writes; C gets extra starts while busy.
        done_a.delete();
        dn_c  = 0;
        st[0] = 1'b1;
        k = cyc + 1;
        for (int t = 0; t < 5170; t++) begin
            en[0] = ($urandom_range(0, 3) == 0); addr[0] = 3'($urandom_range(0, 1));
            data[0] = $urandom;
            en[1] = ($urandom_range(0, 3) == 0); addr[1] = 3'($urandom_range(0, 7));
            data[1] = $urandom;
            st[2] = (t == 0) || (t > 5 && t < 1600 && $urandom_range(0, 7) == 0);
            tick();
        end
        st[0] = 1'b0; st[2] = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
        chk("held_done_count", done_a.size(), 3);
        chk("held_first_done", done_a.size() > 0 ? done_a[0] : -1, k + 1722);
        chk("held_spacing_1", done_a.size() > 1 ? done_a[1] - done_a[0] : -1, 1722);
        chk("held_spacing_2", done_a.size() > 2 ? done_a[2] - done_a[1] : -1, 1722);
        chk("c_frames", dn_c, 1);
        wait_done(0, 2000);
        tick();

        // Reset in the middle of a frame.
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (300) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_led_a", int'(led_a), 1);
        chk("midrst_busy_a", int'(ia.busy), 0);
        chk("midrst_done_a", int'(ia.done), 0);
        rst_n = 1'b1;
        sz = done_a.size();
        repeat (2000) tick();
        chk("midrst_no_done", done_a.size(), sz);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
